// File: rtl/alu_issue.sv
// alu_issue: issue/writeback stage for a 64-bit integer ALU.
//
// The stage takes one RV64I instruction at a time over a valid/ready
// handshake and runs it through three states: IDLE, EXEC and WB. In EXEC it
// reads operands from a 32x64 register file and drives the external
// combinational ALU. It captures the result at the end of EXEC. In WB it
// writes the result back to the register file. Only ADD/SUB/XOR/OR/AND and
// ADDI/XORI/ORI/ANDI are legal. Any other encoding raises a one-cycle illegal
// pulse in EXEC and is dropped.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   instr_valid/ready      instruction handshake (ready only in IDLE)
//   instr                  32-bit instruction word
//   alu_func, alu_sign     ALU function select / subtract flag (EXEC only)
//   alu_op_a, alu_op_b     ALU operands (EXEC only, zero otherwise)
//   alu_res                combinational ALU result
//   wb_valid, wb_rd,       one-cycle writeback strobe, destination, value
//   wb_data
//   illegal                one-cycle unsupported-instruction pulse
//   dbg_addr, dbg_data     combinational register file debug read port
module alu_issue #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [2:0]      alu_func,
  output logic            alu_sign,
  output logic [XLEN-1:0] alu_op_a,
  output logic [XLEN-1:0] alu_op_b,
  input  logic [XLEN-1:0] alu_res,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  state_t          state_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] regs_q [NREGS];

  // Instruction fields, taken from the latched IR.
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm    = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};

  // Decode. funct3 values 000/100/110/111 map straight onto the ALU function
  // select. SUB is the only funct7=0100000 form that is supported.
  logic f3_ok;
  logic is_op;
  logic is_opimm;
  logic legal;

  assign f3_ok    = (funct3 == 3'b000) || (funct3 == 3'b100) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);
  assign is_op    = (opcode == OPC_OP) &&
                    (((funct7 == 7'b0000000) && f3_ok) ||
                     ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
  assign is_opimm = (opcode == OPC_OP_IMM) && f3_ok;
  assign legal    = is_op || is_opimm;

  // Register file reads. x0 is never written, but the reads still gate it so
  // that x0 reads as zero regardless of what the storage holds.
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_val  = (rs1 == 5'd0)      ? '0 : regs_q[rs1];
  assign rs2_val  = (rs2 == 5'd0)      ? '0 : regs_q[rs2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

  // Outputs come straight from the state register. They are also masked by
  // rst, so a reset in EXEC or WB suppresses the strobe of that same cycle.
  logic exec_legal;

  assign exec_legal  = (state_q == S_EXEC) && legal && !rst;
  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign illegal     = (state_q == S_EXEC) && !legal && !rst;
  assign wb_valid    = (state_q == S_WB) && !rst;
  assign wb_rd       = rd;
  assign wb_data     = result_q;
  assign alu_func    = exec_legal ? funct3 : 3'b000;
  assign alu_sign    = exec_legal && is_op && funct7[5];
  assign alu_op_a    = exec_legal ? rs1_val : '0;
  assign alu_op_b    = exec_legal ? (is_opimm ? imm : rs2_val) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      result_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ir_q    <= instr;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (legal) begin
            result_q <= alu_res;
            state_q  <= S_WB;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WB: begin
          if (rd != 5'd0) begin
            regs_q[rd] <= result_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Sequential issue/writeback stage that drives the 64-bit integer ALU's func/sign/op_a/op_b inputs and consumes its combinational res output.
- Accepts one 32-bit RV64I instruction at a time over a valid/ready handshake and decodes the OP and OP-IMM subset the ALU implements (ADD/SUB/XOR/OR/AND and their immediate forms).
- Reads operands from an internal 32x64 register file, captures the ALU result and writes it back.
- Sits between fetch and the ALU; an unsupported encoding raises a one-cycle illegal pulse.

Parameters:
XLEN, 64, datapath and register width (ALU is fixed at 64; other values unsupported)
NREGS, 32, register count (x0 hardwired zero)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  block can accept (IDLE only)
instr  input  32  RV64I instruction word
alu_func  output  3  ALU function select
alu_sign  output  1  1 = SUB when alu_func = add
alu_op_a  output  64  ALU operand A
alu_op_b  output  64  ALU operand B
alu_res  input  64  ALU combinational result
wb_valid  output  1  one-cycle writeback strobe
wb_rd  output  5  destination register of writeback
wb_data  output  64  written value
illegal  output  1  one-cycle unsupported-instruction pulse
dbg_addr  input  5  debug register read address
dbg_data  output  64  combinational regfile read (x0 reads 0)

Behaviour:
- States: IDLE, EXEC, WB. IDLE -> EXEC on instr_valid & instr_ready (instr latched into IR). EXEC -> WB if legal, EXEC -> IDLE if illegal. WB -> IDLE unconditionally. Throughput one instruction per 3 cycles; no back-to-back hazards possible.
- instr_ready = 1 exactly when state = IDLE; instr ignored otherwise.
- Decode (from IR):
  - opcode 0110011, funct7 0000000: funct3 000 ADD, 100 XOR, 110 OR, 111 AND.
  - opcode 0110011, funct7 0100000 + funct3 000: SUB (sign = 1).
  - opcode 0010011, funct3 000/100/110/111: ADDI/XORI/ORI/ANDI; op_b = sign-extended instr[31:20]; sign = 0.
  - Everything else illegal (incl. SLL/SLT/SLTU/SRL/SRA, OP-32, loads/stores).
- alu_func = IR funct3.
- EXEC: alu_op_a = x[rs1], alu_op_b = x[rs2] or imm; alu_func/alu_sign valid. alu_res registered into result at end of EXEC. Outside EXEC (and in EXEC for illegal): alu_func = 0, alu_sign = 0, operands = 0.
- WB: wb_valid = 1, wb_rd = rd, wb_data = result; regfile written at end of WB cycle unless rd = 0. wb_valid still pulses for rd = 0, but x0 stays 0.
- illegal = 1 for the single EXEC cycle of an illegal instruction; no wb_valid, no register change.
- All arithmetic modulo 2^64; no overflow/flag reporting.
- Reset: state IDLE, IR/result = 0, all registers = 0, instr_ready = 1 the cycle after reset deasserts, wb_valid = illegal = 0, ALU outputs 0. Reset in EXEC or WB aborts the instruction: no writeback, no illegal pulse.
- rst has priority over every other event in the same cycle.

Test Plan:
1. Reset, then ADDI x1,x0,5 (0x00500093) -> instr_ready low 2 cycles; wb_valid one cycle, wb_rd=1, wb_data=5; dbg x1=5.
2. ADDI x2,x0,-3 (0xFFD00113), then ADD x3,x1,x2 (0x002081B3) -> x2=0xFFFFFFFFFFFFFFFD; in ADD EXEC alu_func=000, alu_sign=0; x3=2.
3. SUB x4,x1,x2 (0x40208233) -> alu_sign=1 in EXEC, x4=8. XOR x5,x1,x2 (0x0020C2B3) -> x5=0xFFFFFFFFFFFFFFF8.
4. SLL x3,x1,x2 (0x002091B3) -> illegal pulses one cycle, no wb_valid, x3 stays 2; next instr accepted 2 cycles after its acceptance.
5. ADDI x0,x0,7 (0x00700013) -> wb_valid with wb_rd=0, wb_data=7; dbg x0=0.
6. Hold instr_valid high continuously; assert rst during WB of ANDI x6,x1,3 (0x0030F313) -> no wb_valid that cycle; state IDLE; x6=0 and x1=0 (regfile cleared).
